// File: rtl/mxint_pkg.sv
// Shared types and elaboration helpers for the MxInt-to-fixed dequantiser.
package mxint_pkg;

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Exponent bias for a biased exponent of the given width
    function automatic int ebias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    // Largest positive value of a signed field; the negative limit mirrors it
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Signed width that holds the per-block shift amount without overflow
    function automatic int shift_width(input int exp_w, input int man_w, input int out_w);
        return max3(exp_w, $clog2(man_w + out_w), 1) + 2;
    endfunction

endpackage

// File: rtl/mxint_elem_to_fixed.sv
// Combinational conversion of one mantissa and a signed shift into a saturated fixed-point value.
module mxint_elem_to_fixed
    import mxint_pkg::*;
#(
    parameter int unsigned MAN_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT_WIDTH = 10
) (
    input  logic signed [MAN_WIDTH-1:0]   man_i,
    input  logic signed [SHIFT_WIDTH-1:0] shift_i,
    output logic signed [OUT_WIDTH-1:0]   fixed_c
);

    // Wide enough for any in-range left shift of the mantissa
    localparam int unsigned WW = MAN_WIDTH + OUT_WIDTH;

    localparam logic signed [SHIFT_WIDTH-1:0] SH_HI = SHIFT_WIDTH'(OUT_WIDTH);
    localparam logic signed [SHIFT_WIDTH-1:0] SH_LO = SHIFT_WIDTH'(-int'(MAN_WIDTH));
    localparam logic signed [WW-1:0]          SAT_W = WW'(sat_max(int'(OUT_WIDTH)));
    localparam logic signed [OUT_WIDTH-1:0]   SAT_O = OUT_WIDTH'(sat_max(int'(OUT_WIDTH)));

    logic signed [WW-1:0]          man_ext;
    logic signed [WW-1:0]          shl;
    logic signed [SHIFT_WIDTH-1:0] neg_shift;
    logic signed [MAN_WIDTH-1:0]   shr;
    logic                          neg;

    // Range classification first, then scale; saturation is symmetric about zero
    always_comb begin
        man_ext   = WW'(man_i);
        shl       = man_ext <<< $unsigned(shift_i);
        neg_shift = -shift_i;
        shr       = man_i >>> $unsigned(neg_shift);
        neg       = man_i[MAN_WIDTH-1];
        fixed_c   = '0;

        if (man_i == '0) begin
            fixed_c = '0;
        end else if (shift_i >= SH_HI) begin
            fixed_c = neg ? -SAT_O : SAT_O;
        end else if (shift_i <= SH_LO) begin
            fixed_c = {OUT_WIDTH{neg}};
        end else if (!shift_i[SHIFT_WIDTH-1]) begin
            if (shl > SAT_W) begin
                fixed_c = SAT_O;
            end else if (shl < -SAT_W) begin
                fixed_c = -SAT_O;
            end else begin
                fixed_c = shl[OUT_WIDTH-1:0];
            end
        end else begin
            fixed_c = OUT_WIDTH'(shr);
        end
    end

endmodule

// File: rtl/mxint_to_fixed.sv
// Dequantises one MxInt block per input handshake and streams it out OUT_PARALLELISM elements per beat.
module mxint_to_fixed
    import mxint_pkg::*;
#(
    parameter int unsigned MAN_WIDTH       = 8,
    parameter int unsigned EXP_WIDTH       = 8,
    parameter int unsigned BLOCK_SIZE      = 4,
    parameter int unsigned OUT_PARALLELISM = 2,
    parameter int unsigned OUT_WIDTH       = 16,
    parameter int unsigned OUT_FRAC_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
    input  logic        [EXP_WIDTH-1:0] edata_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [OUT_PARALLELISM],
    output logic                        data_out_valid,
    input  logic                        data_out_ready,
    output logic                        data_out_last
);

    localparam int unsigned NBEATS    = BLOCK_SIZE / OUT_PARALLELISM;
    localparam int unsigned BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned SHIFT_W   = shift_width(int'(EXP_WIDTH), int'(MAN_WIDTH), int'(OUT_WIDTH));
    localparam int          SHIFT_OFS = int'(OUT_FRAC_WIDTH) - ebias(int'(EXP_WIDTH)) - (int'(MAN_WIDTH) - 2);

    generate
        if ((BLOCK_SIZE % OUT_PARALLELISM) != 0) begin : g_bad_par
            $error("BLOCK_SIZE must be a multiple of OUT_PARALLELISM");
        end
    endgenerate

    state_e                      state_q, state_d;
    logic        [BEAT_W-1:0]    beat_q, beat_d, beat_nxt;
    logic signed [OUT_WIDTH-1:0] hold_q [BLOCK_SIZE];
    logic signed [OUT_WIDTH-1:0] hold_d [BLOCK_SIZE];
    logic signed [OUT_WIDTH-1:0] dout_q [OUT_PARALLELISM];
    logic signed [OUT_WIDTH-1:0] dout_d [OUT_PARALLELISM];
    logic                        valid_q, valid_d;
    logic                        last_q, last_d;

    logic signed [SHIFT_W-1:0]   shift_c;
    logic signed [OUT_WIDTH-1:0] conv_c [BLOCK_SIZE];
    logic                        in_hs, out_hs;

    // Block shift: unbias the exponent and realign mantissa fraction bits to the output format
    assign shift_c = SHIFT_W'({1'b0, edata_in}) + SHIFT_W'(SHIFT_OFS);

    generate
        for (genvar g = 0; g < int'(BLOCK_SIZE); g++) begin : g_elem
            mxint_elem_to_fixed #(
                .MAN_WIDTH  (MAN_WIDTH),
                .OUT_WIDTH  (OUT_WIDTH),
                .SHIFT_WIDTH(SHIFT_W)
            ) u_elem (
                .man_i  (mdata_in[g]),
                .shift_i(shift_c),
                .fixed_c(conv_c[g])
            );
        end
    endgenerate

    // Accept when idle, or when the final beat leaves this cycle
    assign data_in_ready = (state_q == EMPTY) ||
                           ((state_q == STREAM) && last_q && data_out_ready);
    assign in_hs         = data_in_valid && data_in_ready;
    assign out_hs        = valid_q && data_out_ready;
    assign beat_nxt      = BEAT_W'(beat_q + 1'b1);

    // Next-state, beat counter, holding register and registered output beat
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            EMPTY:   if (in_hs) state_d = STREAM;
            STREAM:  if (out_hs && last_q && !in_hs) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (in_hs) begin
            hold_d  = conv_c;
            beat_d  = '0;
            valid_d = 1'b1;
            last_d  = (NBEATS == 1);
            for (int p = 0; p < int'(OUT_PARALLELISM); p++) begin
                dout_d[p] = conv_c[p];
            end
        end else if (out_hs) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                beat_d = beat_nxt;
                last_d = (beat_nxt == BEAT_W'(NBEATS - 1));
                for (int p = 0; p < int'(OUT_PARALLELISM); p++) begin
                    dout_d[p] = hold_q[int'(beat_nxt) * int'(OUT_PARALLELISM) + p];
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            beat_q  <= '0;
            hold_q  <= '{default: '0};
            dout_q  <= '{default: '0};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = valid_q;
    assign data_out_last  = last_q;

endmodule

// File: tb/tb_mxint_to_fixed.sv
// Randomised and directed bench for mxint_to_fixed against an arithmetic reference model.
module tb_mxint_to_fixed;

    localparam int MW = 8;
    localparam int EW = 8;
    localparam int BS = 4;
    localparam int OP = 2;
    localparam int OW = 16;
    localparam int OF = 8;
    localparam int NB = BS / OP;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [MW-1:0] mdata_in [BS];
    logic        [EW-1:0] edata_in;
    logic                 data_in_valid = 1'b0;
    logic                 data_in_ready;
    logic signed [OW-1:0] data_out [OP];
    logic                 data_out_valid;
    logic                 data_out_ready = 1'b1;
    logic                 data_out_last;

    typedef struct {
        int d [OP];
        bit last;
    } beat_t;

    beat_t exp_q [$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    bit    rnd_mode = 1'b0;
    bit    ready_force = 1'b1;
    bit    prev_in_hs = 1'b0;
    bit    prev_stall = 1'b0;
    int    prev_d [OP];
    int    prev_last;

    mxint_to_fixed #(
        .MAN_WIDTH(MW), .EXP_WIDTH(EW), .BLOCK_SIZE(BS),
        .OUT_PARALLELISM(OP), .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(OF)
    ) dut (
        .clk(clk), .rst(rst),
        .mdata_in(mdata_in), .edata_in(edata_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .data_out_last(data_out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output-ready driver: either a forced level or random backpressure
    always @(posedge clk) begin
        #1;
        data_out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Real-valued meaning: m * 2^(e - bias - (MW-2)) scaled by 2^OF, floored and clamped
    function automatic int ref_conv(input int m, input int e);
        int sh, sat, v, d;
        sh  = e - ((1 << (EW - 1)) - 1) - (MW - 2) + OF;
        sat = (1 << (OW - 1)) - 1;
        if (m == 0) return 0;
        if (sh >= OW) return (m > 0) ? sat : -sat;
        if (sh <= -MW) return (m > 0) ? 0 : -1;
        if (sh >= 0) begin
            v = m * (1 << sh);
            if (v > sat) return sat;
            if (v < -sat) return -sat;
            return v;
        end
        d = 1 << (-sh);
        v = m / d;
        if ((m % d) != 0 && m < 0) v = v - 1;
        return v;
    endfunction

    // Monitor: scoreboard on handshakes, latency and stall-stability checks
    always @(negedge clk) begin
        if (!rst) begin
            prev_in_hs = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_in_hs) check("latency_valid", int'(data_out_valid), 1);
            if (prev_stall) begin
                for (int p = 0; p < OP; p++) check("stall_data", int'(data_out[p]), prev_d[p]);
                check("stall_last", int'(data_out_last), prev_last);
                check("stall_valid", int'(data_out_valid), 1);
            end
            if (data_out_valid && !data_out_ready) check("stall_in_ready", int'(data_in_ready), 0);
            if (data_out_valid && data_out_ready) begin
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    for (int p = 0; p < OP; p++) check("beat_data", int'(data_out[p]), b.d[p]);
                    check("beat_last", int'(data_out_last), int'(b.last));
                end
            end
            prev_stall = data_out_valid && !data_out_ready;
            for (int p = 0; p < OP; p++) prev_d[p] = int'(data_out[p]);
            prev_last = int'(data_out_last);
            prev_in_hs = data_in_valid && data_in_ready;
            if (prev_in_hs) begin
                for (int bi = 0; bi < NB; bi++) begin
                    beat_t nb;
                    for (int p = 0; p < OP; p++)
                        nb.d[p] = ref_conv(int'(mdata_in[bi * OP + p]), int'(edata_in));
                    nb.last = (bi == NB - 1);
                    exp_q.push_back(nb);
                end
            end
        end
    end

    task automatic set_block(input int m0, input int m1, input int m2, input int m3, input int e);
        mdata_in[0] = MW'(m0);
        mdata_in[1] = MW'(m1);
        mdata_in[2] = MW'(m2);
        mdata_in[3] = MW'(m3);
        edata_in    = EW'(e);
    endtask

    task automatic send_block(input int m0, input int m1, input int m2, input int m3, input int e);
        bit hs;
        hs = 1'b0;
        set_block(m0, m1, m2, m3, e);
        data_in_valid = 1'b1;
        for (int t = 0; t < 60 && !hs; t++) begin
            @(negedge clk);
            if (data_in_ready) hs = 1'b1;
        end
        check("in_handshake", int'(hs), 1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int prev_cyc;
        set_block(0, 0, 0, 0, 0);

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_last", int'(data_out_last), 0);
        check("rst_d0", int'(data_out[0]), 0);
        check("rst_d1", int'(data_out[1]), 0);
        check("rst_in_ready", int'(data_in_ready), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed blocks covering scaling, saturation, underflow and floor rounding
        send_block(64, -64, 32, 0, 127);
        drain();
        send_block(64, 127, -128, 1, 130);
        send_block(127, -128, 1, 0, 140);
        send_block(5, -5, 127, -1, 115);
        send_block(3, -3, 1, -1, 124);
        send_block(1, -1, 100, -100, 141);
        send_block(-128, 127, 64, -7, 117);
        drain();

        // Backpressure on the second beat for three cycles
        send_block(10, -20, 30, -40, 128);
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        ready_force = 1'b1;
        drain();

        // Back-to-back: input held valid, each accept lands on a final beat
        @(posedge clk);
        #1;
        data_in_valid = 1'b1;
        prev_cyc = 0;
        for (int b = 0; b < 3; b++) begin
            bit hs;
            hs = 1'b0;
            set_block(b * 11 + 1, -(b * 7 + 3), 90 - b, b - 60, 126 + b);
            for (int t = 0; t < 20 && !hs; t++) begin
                @(negedge clk);
                if (data_in_ready) hs = 1'b1;
            end
            check("b2b_handshake", int'(hs), 1);
            if (b > 0) begin
                check("b2b_on_last", int'(data_out_valid && data_out_last), 1);
                check("b2b_gap", cyc - prev_cyc, NB);
            end
            prev_cyc = cyc;
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        drain();

        // Reset asserted during the final beat of a block
        send_block(50, 60, 70, 80, 127);
        @(posedge clk);
        #1;
        check("pre_rst_last", int'(data_out_valid && data_out_last), 1);
        rst = 1'b0;
        #1;
        check("midrst_valid", int'(data_out_valid), 0);
        check("midrst_last", int'(data_out_last), 0);
        check("midrst_d0", int'(data_out[0]), 0);
        check("midrst_d1", int'(data_out[1]), 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_block(-3, 9, -27, 81, 129);
        drain();

        // Random blocks under random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int e;
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(110, 145));
            send_block(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
                       int'($signed(8'($urandom))), int'($signed(8'($urandom))), e);
        end
        drain();
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
